// File: rtl/dec_to_bcd_pkg.sv
// Shared widths and state encoding for the binary-to-BCD display converter.
package dec_to_bcd_pkg;

  localparam int unsigned BIN_W      = 9;
  localparam int unsigned BCD_DIGITS = 3;
  localparam int unsigned BCD_W      = 12;
  localparam int unsigned WORK_W     = BCD_W + BIN_W;

  // Counter value during the ninth and final shift.
  localparam logic [3:0] LAST_ITER = 4'd8;

  typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/dec_to_bcd_add3.sv
// Double-dabble digit adjust: add 3 to a BCD nibble that is 5 or more.
module dec_to_bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  // 9 + 3 = 12 is the largest result, so no carry is possible.
  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/dec_to_bcd.sv
// Sequential 9-bit binary to 3-digit BCD converter, one shift-and-add-3 step per clock.
module dec_to_bcd
  import dec_to_bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [WORK_W-1:0]   work_q;
  logic [WORK_W-1:0]   adj;
  logic [WORK_W-1:0]   shifted;
  logic [BCD_W-1:0]    bcd_q;
  logic                done_q;

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
    dec_to_bcd_add3 u_add3 (
      .nibble   (work_q[BIN_W + 4*d +: 4]),
      .adjusted (adj[BIN_W + 4*d +: 4])
    );
  end

  assign adj[BIN_W-1:0] = work_q[BIN_W-1:0];
  assign shifted        = {adj[WORK_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q  <= {{BCD_W{1'b0}}, binary};
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= shifted;
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == LAST_ITER) begin
            // Result is published only once, whole, so bcd never shows partial digits.
            bcd_q   <= shifted[WORK_W-1:BIN_W];
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_dec_to_bcd.sv
// Self-checking bench for dec_to_bcd: behavioural model, directed boundaries, random traffic.
module tb_dec_to_bcd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  binary;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int vectors;
  int miscompares;

  dec_to_bcd u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .binary (binary),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference: a conversion accepted while idle finishes 9 edges later.
  int          m_left;
  logic [8:0]  m_val;
  logic        m_busy;
  logic        m_done;
  logic [11:0] m_bcd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_val  <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_bcd  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_bcd  <= to_bcd(int'(m_val));
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (start) begin
        m_val  <= binary;
        m_left <= 9;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if ({busy, done, bcd} !== {m_busy, m_done, m_bcd}) begin
      miscompares++;
      $display("FAIL cycle_cmp t=%0t got busy=%b done=%b bcd=%h want busy=%b done=%b bcd=%h",
               $time, busy, done, bcd, m_busy, m_done, m_bcd);
    end
  end

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic convert(input int val, input logic [11:0] exp, input string name);
    int n;
    n = 0;
    @(negedge clk);
    start  = 1'b1;
    binary = 9'(val);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
    check({name, "_latency"}, 12'(n), 12'd9);
    check(name, bcd, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    start       = 1'b0;
    binary      = '0;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;

    // Pin the reference arithmetic with hand-computed values.
    check("model_0",   to_bcd(0),   12'h000);
    check("model_255", to_bcd(255), 12'h255);
    check("model_511", to_bcd(511), 12'h511);
    check("model_37",  to_bcd(37),  12'h037);

    repeat (3) @(posedge clk);
    #1;
    check("reset_bcd",  bcd,          12'h000);
    check("reset_busy", 12'(busy),    12'h000);
    check("reset_done", 12'(done),    12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    convert(0,   12'h000, "conv_0");
    convert(511, 12'h511, "conv_511");
    convert(9,   12'h009, "conv_9");
    convert(10,  12'h010, "conv_10");
    convert(100, 12'h100, "conv_100");
    convert(255, 12'h255, "conv_255");

    // Exhaustive, back-to-back with start held high.
    @(negedge clk);
    start  = 1'b1;
    binary = '0;
    for (int i = 0; i < 512; i++) begin
      @(posedge clk);
      #1;
      check("b2b_busy", 12'(busy), 12'h001);
      repeat (9) @(posedge clk);
      #1;
      check("b2b_done", 12'(done), 12'h001);
      check("b2b_value", 12'(int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0])),
            12'(i));
      binary = 9'(i + 1);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);

    // Start and operand change while busy must not disturb the conversion.
    @(negedge clk);
    start  = 1'b1;
    binary = 9'd123;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start  = 1'b1;
    binary = 9'd456;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    check("busy_protect", bcd, 12'h123);
    check("busy_protect_done", 12'(done), 12'h001);

    // Reset in the middle of a conversion.
    @(negedge clk);
    start  = 1'b1;
    binary = 9'd399;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_bcd",  bcd,       12'h000);
    check("midrst_busy", 12'(busy), 12'h000);
    check("midrst_done", 12'(done), 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_done", 12'(done), 12'h000);
    end
    convert(37, 12'h037, "conv_37");

    // Result must hold while idle regardless of operand activity.
    convert(250, 12'h250, "conv_250");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      binary = 9'($urandom_range(0, 511));
      @(posedge clk);
      #1;
      check("hold_250", bcd, 12'h250);
    end

    // Random traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) == 0);
      binary = 9'($urandom_range(0, 511));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
